fb_pixel_path: RTL and testbench
================================

# fb_pixel_path

Pixel-fetch datapath between the blitter and the HDMI colour outputs: a 320×480, 8-bit-per-pixel frame buffer (simple dual port), a combinational screen-to-address calculator for a 320-pixel-wide window centred in a 640×480 raster, and a palette stage that turns each stored pixel byte into 4-bit RGB. The blitter writes through port A. The VGA/HDMI timing generator supplies DrawX/DrawY and receives Red/Green/Blue one clock later.

## Interface
- Parameters: none. Window geometry is fixed at X 160..479, Y 0..479, with a row stride of 320.
- Reset: one clock; reset is synchronous and active-low.
- clk_100MHz  in  1  system clock; all state updates on its rising edge.
- aresetn  in  1  synchronous active-low reset.
- FB_addra  in  18  write address from the blitter.
- FB_WEA  in  1  write enable; writes FB_dina at FB_addra on the clock edge.
- FB_dina  in  8  write data: [7:3] sprite code s, [2:0] palette code p.
- DrawX  in  10  current raster column, 0..799.
- DrawY  in  10  current raster row, 0..524.
- FB_addrb  out  18  computed read address (combinational).
- FB_OEB  out  1  read enable: high while (DrawX, DrawY) is inside the window (combinational).
- Red  out  4  pixel colour, red channel.
- Green  out  4  pixel colour, green channel.
- Blue  out  4  pixel colour, blue channel.

## Operation
- Frame buffer:
  - 153600 × 8 RAM, inferred as block RAM.
  - Memory contents are not affected by reset.
  - A write with FB_addra ≥ 153600 is discarded.
- Address calculation:
  - in_win = (160 ≤ DrawX < 480) && (DrawY < 480).
  - When in_win: FB_addrb = DrawY*320 + (DrawX−160), built as (DrawY<<8)+(DrawY<<6)+(DrawX−160) at 18-bit width. FB_OEB = 1.
  - Otherwise: FB_addrb = 0 and FB_OEB = 0.
- Read:
  - When FB_OEB = 1, the RAM output register pix loads mem[FB_addrb] on the clock edge.
  - When FB_OEB = 0, pix holds its value.
  - vld is a register that loads FB_OEB every cycle.
- Palette, combinational from pix and vld:
  - s = pix[7:3], p = pix[2:0], intensity i = s[4:1].
  - If vld = 0 or s = 0: RGB = 0x000 (transparent/background).
  - Else if p = 0: R = G = B = i (grey).
  - Else: R = p[2] ? i : 0, G = p[1] ? i : 0, B = p[0] ? i : 0.
  - s[0] is reserved and ignored.

## Timing
- FB_addrb and FB_OEB have zero latency relative to DrawX/DrawY.
- Red/Green/Blue have exactly one cycle of latency: the colour for the coordinate presented in cycle n is valid after edge n+1.
- Port A write latency is one edge. Data written at edge n is readable by a port-B read issued at edge n+1 or later.
- Same-address collision on one edge (write and read): read-first; pix gets the old contents.
- Reset (aresetn = 0 at an edge):
  - pix ← 0x00 and vld ← 0, so RGB = 0x000 on the next cycle.
  - A write issued in the same cycle as reset is still performed.
  - Reset asserted mid-line blanks output for the cycle after it. Normal output resumes on the first edge after aresetn returns high.
- Window boundaries:
  - DrawX = 159 or 480 gives FB_OEB = 0.
  - DrawX = 479, DrawY = 479 gives FB_addrb = 153599.
  - DrawY ≥ 480 gives FB_OEB = 0.

## Configuration
- FB_BORDER_EN:
  - Defined: when vld = 0 and the delayed coordinate was outside the window, output the border colour R = G = B = 4'h3. This needs a one-cycle-delayed in-raster flag (DrawX < 640 && DrawY < 480); outside the raster the output stays 0x000.
  - Not defined: the outside-window output is 0x000.
  - Transparent pixels (s = 0) inside the window output 0x000 in both cases.

## Test plan
- Write 0x02, 0x19, 0x3A, 0x43, 0x04, 0x79 to addresses 0..5. Then drive DrawY = 0 and DrawX = 160..165 one per cycle. Required RGB one cycle later: 000, 001, 030, 044, 000, 007.
- DrawX = 159, DrawY = 0: FB_OEB = 0, FB_addrb = 0, RGB = 000 (or 333 with FB_BORDER_EN). DrawX = 160: FB_OEB = 1, FB_addrb = 0.
- DrawX = 479, DrawY = 479: FB_addrb = 153599. DrawX = 300, DrawY = 2: FB_addrb = 780. DrawY = 480: FB_OEB = 0.
- Write 0x83 to address 0 and read address 0 on the same edge: read returns the previous byte. Next read returns 0x83, giving RGB 000 → 0,8,8 (palette 3, i = 8).
- Write 0x5C (s = 11, p = 4) to address 10, then read it under aresetn = 0: RGB = 000. Release reset and re-read: RGB = 5,0,0.
- Write 0xF8 to address 153600, then read address 0: the contents are unchanged.

Source files
------------

// File: rtl/fb_pixel_path.sv
// Frame buffer, window address calculator and palette stage from blitter writes to HDMI RGB (optional FB_BORDER_EN border colour).
// Latency: FB_addrb/FB_OEB are combinational; Red/Green/Blue follow DrawX/DrawY by one clock.
// Backpressure: none; the raster drives one coordinate per clock and writes are never stalled.
module fb_pixel_path (
    input  logic        clk_100MHz,
    input  logic        aresetn,
    input  logic [17:0] FB_addra,
    input  logic        FB_WEA,
    input  logic [7:0]  FB_dina,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [17:0] FB_addrb,
    output logic        FB_OEB,
    output logic [3:0]  Red,
    output logic [3:0]  Green,
    output logic [3:0]  Blue
);

    localparam int unsigned FB_DEPTH = 153600;

    logic [7:0]  mem [0:FB_DEPTH-1];
    logic [7:0]  pix;
    logic        vld;
    logic        in_win;
    logic [17:0] x_off;
    logic [17:0] y_base;
    logic [4:0]  s;
    logic [2:0]  p;
    logic [3:0]  i;

    always_comb begin
        in_win   = (DrawX >= 10'd160) && (DrawX < 10'd480) && (DrawY < 10'd480);
        x_off    = {8'd0, DrawX - 10'd160};
        // DrawY*320 as two shifts keeps this a pair of adders
        y_base   = ({8'd0, DrawY} << 8) + ({8'd0, DrawY} << 6);
        FB_addrb = 18'd0;
        FB_OEB   = 1'b0;
        if (in_win) begin
            FB_addrb = y_base + x_off;
            FB_OEB   = 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (FB_WEA && (FB_addra < 18'(FB_DEPTH))) begin
            mem[FB_addra] <= FB_dina;
        end
    end

    // Nonblocking read of mem gives read-first behaviour on a same-address collision
    always_ff @(posedge clk_100MHz) begin
        if (!aresetn) begin
            pix <= 8'h00;
            vld <= 1'b0;
        end else begin
            vld <= FB_OEB;
            if (FB_OEB) begin
                pix <= mem[FB_addrb];
            end
        end
    end

`ifdef FB_BORDER_EN
    logic in_raster_d;

    always_ff @(posedge clk_100MHz) begin
        if (!aresetn) begin
            in_raster_d <= 1'b0;
        end else begin
            in_raster_d <= (DrawX < 10'd640) && (DrawY < 10'd480);
        end
    end
`endif

    always_comb begin
        s     = pix[7:3];
        p     = pix[2:0];
        i     = s[4:1];
        Red   = 4'h0;
        Green = 4'h0;
        Blue  = 4'h0;
        if (vld && (s != 5'd0)) begin
            if (p == 3'd0) begin
                Red   = i;
                Green = i;
                Blue  = i;
            end else begin
                Red   = p[2] ? i : 4'h0;
                Green = p[1] ? i : 4'h0;
                Blue  = p[0] ? i : 4'h0;
            end
        end
`ifdef FB_BORDER_EN
        if (!vld && in_raster_d) begin
            Red   = 4'h3;
            Green = 4'h3;
            Blue  = 4'h3;
        end
`endif
    end

endmodule

// File: tb/tb_fb_pixel_path.sv
// Directed bench for fb_pixel_path: palette decode, window addressing, collisions, reset and discarded writes.
module tb_fb_pixel_path;

    logic        clk_100MHz;
    logic        aresetn;
    logic [17:0] FB_addra;
    logic        FB_WEA;
    logic [7:0]  FB_dina;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [17:0] FB_addrb;
    logic        FB_OEB;
    logic [3:0]  Red;
    logic [3:0]  Green;
    logic [3:0]  Blue;

    int vecs = 0;
    int errs = 0;

`ifdef FB_BORDER_EN
    localparam logic [11:0] BORDER_RGB = 12'h333;
`else
    localparam logic [11:0] BORDER_RGB = 12'h000;
`endif

    fb_pixel_path dut (
        .clk_100MHz (clk_100MHz),
        .aresetn    (aresetn),
        .FB_addra   (FB_addra),
        .FB_WEA     (FB_WEA),
        .FB_dina    (FB_dina),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .FB_addrb   (FB_addrb),
        .FB_OEB     (FB_OEB),
        .Red        (Red),
        .Green      (Green),
        .Blue       (Blue)
    );

    initial begin
        clk_100MHz = 1'b0;
        forever #5 clk_100MHz = ~clk_100MHz;
    end

    task automatic wr(input logic [17:0] a, input logic [7:0] d);
        @(negedge clk_100MHz);
        FB_addra = a;
        FB_dina  = d;
        FB_WEA   = 1'b1;
        @(posedge clk_100MHz);
        #1;
        FB_WEA   = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        DrawX   = 10'd0;
        DrawY   = 10'd0;
        repeat (2) @(posedge clk_100MHz);
        #1;
        vecs++;
        if ({Red, Green, Blue} !== 12'h000)
            $display("FAIL reset_rgb: got %h want 000", {Red, Green, Blue});
        vecs++;
        if (FB_OEB !== 1'b0 || FB_addrb !== 18'd0) begin
            errs++;
            $display("FAIL reset_oeb: oeb=%b addrb=%0d want 0/0", FB_OEB, FB_addrb);
        end
        if ({Red, Green, Blue} !== 12'h000) errs++;
        @(negedge clk_100MHz);
        aresetn = 1'b1;
    endtask

    task automatic test_palette();
        logic [7:0]  wdat [6];
        logic [11:0] want [6];
        logic [11:0] got;
        wdat = '{8'h02, 8'h19, 8'h3A, 8'h43, 8'h04, 8'h79};
        want = '{12'h000, 12'h001, 12'h030, 12'h044, 12'h000, 12'h007};
        for (int k = 0; k < 6; k++) wr(18'(k), wdat[k]);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_100MHz);
            DrawX = 10'(160 + k);
            DrawY = 10'd0;
            @(posedge clk_100MHz);
            #1;
            got = {Red, Green, Blue};
            vecs++;
            if (got !== want[k]) begin
                errs++;
                $display("FAIL palette[%0d]: got %h want %h", k, got, want[k]);
            end
        end
        // Outside the window the held pixel must not reach the output
        @(negedge clk_100MHz);
        DrawX = 10'd480;
        @(posedge clk_100MHz);
        #1;
        vecs++;
        if ({Red, Green, Blue} !== BORDER_RGB) begin
            errs++;
            $display("FAIL hold_blank: got %h want %h", {Red, Green, Blue}, BORDER_RGB);
        end
    endtask

    task automatic test_boundary();
        @(negedge clk_100MHz);
        DrawX = 10'd159;
        DrawY = 10'd0;
        #1;
        vecs++;
        if (FB_OEB !== 1'b0 || FB_addrb !== 18'd0) begin
            errs++;
            $display("FAIL x159: oeb=%b addrb=%0d want 0/0", FB_OEB, FB_addrb);
        end
        @(posedge clk_100MHz);
        #1;
        vecs++;
        if ({Red, Green, Blue} !== BORDER_RGB) begin
            errs++;
            $display("FAIL x159_rgb: got %h want %h", {Red, Green, Blue}, BORDER_RGB);
        end
        @(negedge clk_100MHz);
        DrawX = 10'd160;
        #1;
        vecs++;
        if (FB_OEB !== 1'b1 || FB_addrb !== 18'd0) begin
            errs++;
            $display("FAIL x160: oeb=%b addrb=%0d want 1/0", FB_OEB, FB_addrb);
        end
        @(negedge clk_100MHz);
        DrawX = 10'd479;
        DrawY = 10'd479;
        #1;
        vecs++;
        if (FB_OEB !== 1'b1 || FB_addrb !== 18'd153599) begin
            errs++;
            $display("FAIL last_px: oeb=%b addrb=%0d want 1/153599", FB_OEB, FB_addrb);
        end
        @(negedge clk_100MHz);
        DrawX = 10'd300;
        DrawY = 10'd2;
        #1;
        vecs++;
        if (FB_OEB !== 1'b1 || FB_addrb !== 18'd780) begin
            errs++;
            $display("FAIL x300y2: oeb=%b addrb=%0d want 1/780", FB_OEB, FB_addrb);
        end
        @(negedge clk_100MHz);
        DrawX = 10'd480;
        DrawY = 10'd0;
        #1;
        vecs++;
        if (FB_OEB !== 1'b0 || FB_addrb !== 18'd0) begin
            errs++;
            $display("FAIL x480: oeb=%b addrb=%0d want 0/0", FB_OEB, FB_addrb);
        end
        @(negedge clk_100MHz);
        DrawX = 10'd200;
        DrawY = 10'd480;
        #1;
        vecs++;
        if (FB_OEB !== 1'b0 || FB_addrb !== 18'd0) begin
            errs++;
            $display("FAIL y480: oeb=%b addrb=%0d want 0/0", FB_OEB, FB_addrb);
        end
        @(posedge clk_100MHz);
        #1;
        vecs++;
        if ({Red, Green, Blue} !== 12'h000) begin
            errs++;
            $display("FAIL y480_rgb: got %h want 000", {Red, Green, Blue});
        end
    endtask

    task automatic test_collision();
        @(negedge clk_100MHz);
        FB_addra = 18'd0;
        FB_dina  = 8'h83;
        FB_WEA   = 1'b1;
        DrawX    = 10'd160;
        DrawY    = 10'd0;
        @(posedge clk_100MHz);
        #1;
        vecs++;
        if ({Red, Green, Blue} !== 12'h000) begin
            errs++;
            $display("FAIL collide_old: got %h want 000", {Red, Green, Blue});
        end
        @(negedge clk_100MHz);
        FB_WEA = 1'b0;
        @(posedge clk_100MHz);
        #1;
        vecs++;
        if ({Red, Green, Blue} !== 12'h088) begin
            errs++;
            $display("FAIL collide_new: got %h want 088", {Red, Green, Blue});
        end
    endtask

    task automatic test_reset_midline();
        // Write issued during reset must still land
        @(negedge clk_100MHz);
        aresetn  = 1'b0;
        FB_addra = 18'd10;
        FB_dina  = 8'h5C;
        FB_WEA   = 1'b1;
        DrawX    = 10'd170;
        DrawY    = 10'd0;
        @(posedge clk_100MHz);
        #1;
        vecs++;
        if ({Red, Green, Blue} !== 12'h000) begin
            errs++;
            $display("FAIL rst_wr_rgb: got %h want 000", {Red, Green, Blue});
        end
        @(negedge clk_100MHz);
        aresetn = 1'b1;
        FB_WEA  = 1'b0;
        @(posedge clk_100MHz);
        #1;
        vecs++;
        if ({Red, Green, Blue} !== 12'h500) begin
            errs++;
            $display("FAIL rst_release: got %h want 500", {Red, Green, Blue});
        end
        @(negedge clk_100MHz);
        aresetn = 1'b0;
        DrawX   = 10'd161;
        @(posedge clk_100MHz);
        #1;
        vecs++;
        if ({Red, Green, Blue} !== 12'h000) begin
            errs++;
            $display("FAIL rst_mid: got %h want 000", {Red, Green, Blue});
        end
        @(negedge clk_100MHz);
        aresetn = 1'b1;
        @(posedge clk_100MHz);
        #1;
        vecs++;
        if ({Red, Green, Blue} !== 12'h001) begin
            errs++;
            $display("FAIL rst_resume: got %h want 001", {Red, Green, Blue});
        end
    endtask

    task automatic test_oob_write();
        wr(18'd153599, 8'h19);
        wr(18'd153600, 8'hF8);
        @(negedge clk_100MHz);
        DrawX = 10'd160;
        DrawY = 10'd0;
        @(posedge clk_100MHz);
        #1;
        vecs++;
        if ({Red, Green, Blue} !== 12'h088) begin
            errs++;
            $display("FAIL oob_addr0: got %h want 088", {Red, Green, Blue});
        end
        @(negedge clk_100MHz);
        DrawX = 10'd479;
        DrawY = 10'd479;
        @(posedge clk_100MHz);
        #1;
        vecs++;
        if ({Red, Green, Blue} !== 12'h001) begin
            errs++;
            $display("FAIL oob_last: got %h want 001", {Red, Green, Blue});
        end
    endtask

    initial begin
        aresetn  = 1'b0;
        FB_addra = 18'd0;
        FB_WEA   = 1'b0;
        FB_dina  = 8'h00;
        DrawX    = 10'd0;
        DrawY    = 10'd0;
        test_reset();
        test_palette();
        test_boundary();
        test_collision();
        test_reset_midline();
        test_oob_write();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
